// File: rtl/iter_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle, result as {quotient, remainder}.
// Operands arrive on two independent valid/ready channels; the result is a one-cycle pulse.
module iter_divider #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
);
  // Handshake: a channel transfers on an edge where tvalid && tready are both high.
  // tready is high only in IDLE while that channel holds no operand; the result side
  // has no back-pressure, tvalid is a single-cycle pulse and tdata holds afterwards.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_nxt;

  logic               held_dvd, held_dvs;
  logic [WIDTH-1:0]   dvd_q, dvs_q;
  logic [WIDTH-1:0]   rem, dq, dvs_mag;
  logic [CW-1:0]      cnt;
  logic               neg_q, neg_r;
  logic [2*WIDTH-1:0] dout;

  logic               dvd_fire, dvs_fire, start;
  logic               dvd_neg, dvs_neg;
  logic [WIDTH-1:0]   dvd_sel, dvs_sel, dvd_abs, dvs_abs;
  logic [WIDTH:0]     shifted, trial;

  assign s_axis_dividend_tready = (state == IDLE) && !held_dvd;
  assign s_axis_divisor_tready  = (state == IDLE) && !held_dvs;
  assign dvd_fire = s_axis_dividend_tvalid && s_axis_dividend_tready;
  assign dvs_fire = s_axis_divisor_tvalid && s_axis_divisor_tready;
  assign start    = (held_dvd || dvd_fire) && (held_dvs || dvs_fire);

  assign m_axis_dout_tvalid = (state == DONE);
  assign m_axis_dout_tdata  = dout;

  // An operand captured on the same edge as the start comes straight from the bus.
  always_comb begin
    dvd_sel = held_dvd ? dvd_q : s_axis_dividend_tdata;
    dvs_sel = held_dvs ? dvs_q : s_axis_divisor_tdata;
    dvd_neg = SIGNED && dvd_sel[WIDTH-1];
    dvs_neg = SIGNED && dvs_sel[WIDTH-1];
    dvd_abs = dvd_neg ? -dvd_sel : dvd_sel;
    dvs_abs = dvs_neg ? -dvs_sel : dvs_sel;
    shifted = {rem, dq[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_mag};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_dvd <= 1'b0;
      held_dvs <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem      <= '0;
      dq       <= '0;
      dvs_mag  <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dout     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dvd_fire) begin
            dvd_q    <= s_axis_dividend_tdata;
            held_dvd <= 1'b1;
          end
          if (dvs_fire) begin
            dvs_q    <= s_axis_divisor_tdata;
            held_dvs <= 1'b1;
          end
          if (start) begin
            dq      <= dvd_abs;
            dvs_mag <= dvs_abs;
            rem     <= '0;
            cnt     <= '0;
            neg_q   <= dvd_neg ^ dvs_neg;
            neg_r   <= dvd_neg;
          end
        end
        BUSY: begin
          // The partial remainder never exceeds the divisor, so trial[WIDTH] is a true sign.
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            dq  <= {dq[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            dq  <= {dq[WIDTH-2:0], 1'b0};
          end
          cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
        FIX: dout <= {neg_q ? -dq : dq, neg_r ? -rem : rem};
        DONE: begin
          held_dvd <= 1'b0;
          held_dvs <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/iter_divider.md
# iter_divider

Multi-cycle radix-2 restoring divider that sits behind the execute stage's HI/LO unit. It is the responder end of the divisor/dividend valid-ready handshake, replacing the vendor divider IP for `div`/`divu`. Two instances exist, one with `SIGNED=1` and one with `SIGNED=0`. Each accepts a dividend and a divisor on independent stream channels, iterates one quotient bit per cycle, and presents `{quotient, remainder}` on a one-cycle valid pulse.

## Interface
- `WIDTH`, 32: operand width; output data is `2*WIDTH` bits.
- `SIGNED`, 1: 1 gives two's-complement division; 0 gives unsigned division.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `s_axis_dividend_tvalid`  in  1  dividend offered.
- `s_axis_dividend_tready`  out  1  dividend channel can accept.
- `s_axis_dividend_tdata`  in  WIDTH  dividend.
- `s_axis_divisor_tvalid`  in  1  divisor offered.
- `s_axis_divisor_tready`  out  1  divisor channel can accept.
- `s_axis_divisor_tdata`  in  WIDTH  divisor.
- `m_axis_dout_tvalid`  out  1  result valid for exactly one cycle; there is no back-pressure.
- `m_axis_dout_tdata`  out  2*WIDTH  `[2W-1:W]` is the quotient (goes to LO); `[W-1:0]` is the remainder (goes to HI).

## Operation
- **States:** IDLE, BUSY, FIX, DONE.
- **IDLE, per channel:**
  - `tready = !held_x`.
  - On `tvalid && tready`, latch data and set `held_x`.
  - The two channels are independent: they may arrive in the same cycle or in different cycles, in either order.
  - A second offer on an already-held channel is not accepted.
- **IDLE→BUSY:** occurs on the edge where both channels are held, either already or by a capture at that same edge.
  - Load `|dividend|` and `|divisor|`. Magnitudes are computed only when `SIGNED=1`; with `SIGNED=0` the raw values are loaded.
  - Save `neg_q = sign(dividend) ^ sign(divisor)` and `neg_r = sign(dividend)`, both forced to 0 when `SIGNED=0`.
  - Clear the counter.
- **BUSY, one step per cycle for WIDTH cycles:**
  - `trial = {rem[W-1:0], dq[W-1]} - {1'b0,|divisor|}`, computed at W+1 bits.
  - If `trial` is non-negative: `rem <= trial`, shift 1 into `dq`.
  - Otherwise: `rem <= {rem[W-1:0], dq[W-1]}`, shift 0 into `dq`.
  - The counter wraps at WIDTH-1, giving BUSY→FIX.
- **FIX:**
  - `m_axis_dout_tdata <= {neg_q ? -q : q, neg_r ? -r : r}`.
  - Transition to DONE.
- **DONE:** `m_axis_dout_tvalid = 1`, held flags cleared, transition to IDLE.
- **tready in non-IDLE states:** both `tready` are 0 in BUSY, FIX and DONE; offers made then are ignored (not buffered).
- **Divide by zero** (deterministic, no trap):
  - The magnitude quotient is all ones and the magnitude remainder is `|dividend|`; sign fix-up then applies.
  - Unsigned: q=0xFFFFFFFF, r=dividend.
  - Signed, dividend ≥ 0: q=0xFFFFFFFF.
  - Signed, dividend < 0: q=0x00000001.
  - In both signed cases r=dividend.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0. Magnitudes are treated as unsigned W-bit values.
- **Sign convention:** remainder takes the dividend's sign; quotient truncates toward zero.

## Timing
- **Reset values:**
  - `m_axis_dout_tvalid=0`, `m_axis_dout_tdata=0`.
  - Both `tready=1` (IDLE, held flags clear).
  - All internal registers are 0.
- **Latency:** if both operands are held by the end of cycle 0, BUSY spans cycles 1..W, FIX is cycle W+1, and `tvalid` is high in cycle W+2 (34 for W=32).
- **Throughput:** new operands are accepted in cycle W+3 at the earliest; one result per W+3 cycles.
- **Output hold:** `m_axis_dout_tdata` holds its value until the next FIX, so it stays stable after the pulse.
- **tready timing:** `tready` deasserts the cycle after a channel's capture and reasserts the cycle after DONE.
- **Reset mid-operation:** a reset in any state returns to IDLE the next edge with held flags cleared, tvalid 0 and tdata 0. No pulse is emitted for the aborted operation.
- **Reset with tvalid:** if reset is high in the same cycle as a `tvalid`, the capture is suppressed.

## Test plan
- **Unsigned basic:** `SIGNED=0`, dividend 100 and divisor 7 presented together in cycle 0 -> both tready drop in cycle 1; tvalid only in cycle 34 with tdata {0x0000000E, 0x00000002}.
- **Signed signs:** `SIGNED=1`, three divisions, each result checked at its tvalid pulse:
  - 7 / -2 -> {0xFFFFFFFD, 0x00000001}.
  - -7 / 2 -> {0xFFFFFFFD, 0xFFFFFFFF}.
  - 0x80000000 / 0xFFFFFFFF -> {0x80000000, 0x00000000}.
- **Staggered channels:** divisor offered in cycle 0, dividend in cycle 5 -> divisor tready low from cycle 1 while dividend tready stays high until capture; tvalid in cycle 39.
- **Divide by zero:** unsigned 0x12345678/0 -> {0xFFFFFFFF, 0x12345678}; signed 0xFFFFFFF9/0 -> {0x00000001, 0xFFFFFFF9}.
- **Busy ignore and back-to-back:**
  - Operands held valid continuously -> only one capture per operation.
  - The second operation is captured in cycle 35, and its tvalid comes in cycle 69.
  - tdata stays equal to result 1 between the two pulses.
- **Reset mid-op:** reset pulsed in cycle 10 of a division -> no tvalid ever for that operation; tready=1 and tdata=0 in cycle 11; a fresh 9/3 then gives {3, 0} with correct latency.
